// File: rtl/sumador_completo_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master side drives the operands; the slave (adder) returns the registered result.
interface sumador_completo_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output a,
    output b,
    output cin,
    output in_valid,
    input  sum,
    input  cout,
    input  out_valid
  );

  modport slave (
    input  a,
    input  b,
    input  cin,
    input  in_valid,
    output sum,
    output cout,
    output out_valid
  );
endinterface

// File: rtl/sumador_completo.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one clock of latency.
// WIDTH=1 is a plain registered full adder.
module sumador_completo #(
  parameter int unsigned WIDTH = 1
) (
  input logic               clk,
  input logic               rst_n,
  sumador_completo_if.slave bus
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_q;

  // Carry is kept in a loop variable rather than a vector so the ripple is
  // not seen as a combinational self-dependency.
  always_comb begin
    logic carry;
    carry = bus.cin;
    sum_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_d[i] = bus.a[i] ^ bus.b[i] ^ carry;
      carry    = (bus.a[i] & bus.b[i]) | (carry & (bus.a[i] ^ bus.b[i]));
    end
    cout_d = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sumador_completo.sv
// Directed bench for sumador_completo at WIDTH=1 and WIDTH=4.
module tb_sumador_completo;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sumador_completo_if #(.WIDTH(1)) bus1 ();
  sumador_completo_if #(.WIDTH(4)) bus4 ();

  sumador_completo #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  sumador_completo #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    // inputs nonzero, reset asserted before the first rising edge at t=5
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    bus4.a = 4'hF; bus4.b = 4'hF; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_w1: got cout,sum,ov=%b required 000",
               {bus1.cout, bus1.sum, bus1.out_valid});
    end
    total++;
    if ({bus4.cout, bus4.sum, bus4.out_valid} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_w4: got cout,sum,ov=%b required 000000",
               {bus4.cout, bus4.sum, bus4.out_valid});
    end
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive();
    logic [1:0] exp_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      bus1.b = v[2]; bus1.a = v[1]; bus1.cin = v[0]; bus1.in_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({bus1.cout, bus1.sum} !== exp_tbl[i] || bus1.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL exhaustive_%0d: got cout,sum=%b ov=%b required %b ov=1",
                 i, {bus1.cout, bus1.sum}, bus1.out_valid, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_hold();
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b0; bus1.in_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b101) begin
      bad++;
      $display("FAIL hold_load: got cout,sum,ov=%b required 101",
               {bus1.cout, bus1.sum, bus1.out_valid});
    end
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b100) begin
        bad++;
        $display("FAIL hold_%0d: got cout,sum,ov=%b required 100",
                 k, {bus1.cout, bus1.sum, bus1.out_valid});
      end
    end
  endtask

  task automatic test_reset_midop();
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b111) begin
      bad++;
      $display("FAIL midop_sampled: got cout,sum,ov=%b required 111",
               {bus1.cout, bus1.sum, bus1.out_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL midop_reset: got cout,sum,ov=%b required 000",
               {bus1.cout, bus1.sum, bus1.out_valid});
    end
    rst_n = 1'b1;
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0;
    @(negedge clk);
    total++;
    if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL midop_no_edge: got cout,sum,ov=%b required 000",
               {bus1.cout, bus1.sum, bus1.out_valid});
    end
    @(negedge clk);
    total++;
    if ({bus1.cout, bus1.sum, bus1.out_valid} !== 3'b011) begin
      bad++;
      $display("FAIL midop_fresh: got cout,sum,ov=%b required 011",
               {bus1.cout, bus1.sum, bus1.out_valid});
    end
  endtask

  task automatic test_width4();
    logic [3:0] va [3] = '{4'hF, 4'h8, 4'h3};
    logic [3:0] vb [3] = '{4'hF, 4'h8, 4'h5};
    logic       vc [3] = '{1'b1, 1'b0, 1'b0};
    logic [4:0] ve [3] = '{5'h1F, 5'h10, 5'h08};
    for (int i = 0; i < 3; i++) begin
      bus4.a = va[i]; bus4.b = vb[i]; bus4.cin = vc[i]; bus4.in_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({bus4.cout, bus4.sum} !== ve[i] || bus4.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL width4_%0d: got cout,sum=%h ov=%b required %h ov=1",
                 i, {bus4.cout, bus4.sum}, bus4.out_valid, ve[i]);
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_glitch();
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.in_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({bus1.cout, bus1.sum} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_pre: got cout,sum=%b required 00", {bus1.cout, bus1.sum});
    end
    #1 bus1.a = 1'b1;
    #1 bus1.b = 1'b1;
    #1 bus1.cin = 1'b0;
    #1 begin bus1.b = 1'b1; bus1.a = 1'b0; bus1.cin = 1'b1; end
    total++;
    if ({bus1.cout, bus1.sum} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_between: got cout,sum=%b required 00", {bus1.cout, bus1.sum});
    end
    @(posedge clk);
    #1 bus1.a = 1'b1;
    #1 bus1.cin = 1'b0;
    total++;
    if ({bus1.cout, bus1.sum} !== 2'b10) begin
      bad++;
      $display("FAIL glitch_after_edge: got cout,sum=%b required 10", {bus1.cout, bus1.sum});
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus1.cout, bus1.sum} !== 2'b10) begin
      bad++;
      $display("FAIL glitch_settled: got cout,sum=%b required 10", {bus1.cout, bus1.sum});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    test_reset();
    test_exhaustive();
    test_hold();
    test_reset_midop();
    test_width4();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish required finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
